// File: rtl/trace_cmd_dispatcher.sv
// Trace record dispatcher: validates commands, buffers them in a FIFO and issues decoded requests,
// stalling after CLR/PRINT until cache_done. Optional statistics via TRACE_DISPATCH_STATS_EN.
module trace_cmd_dispatcher #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned OFFSET_BITS = 6,
    parameter int unsigned INDEX_BITS  = 14,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [3:0]                                in_cmd,
    input  logic [ADDR_W-1:0]                         in_addr,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [3:0]                                out_cmd,
    output logic [ADDR_W-1:0]                         out_addr,
    output logic [ADDR_W-INDEX_BITS-OFFSET_BITS-1:0]  out_tag,
    output logic [INDEX_BITS-1:0]                     out_index,
    output logic [OFFSET_BITS-1:0]                    out_offset,
    output logic                                      out_icache,
    input  logic                                      cache_done,
    output logic                                      bad_cmd,
    output logic [$clog2(FIFO_DEPTH):0]               fifo_level
`ifdef TRACE_DISPATCH_STATS_EN
    ,
    output logic [CNT_W-1:0]                          rd_cnt,
    output logic [CNT_W-1:0]                          wr_cnt,
    output logic [CNT_W-1:0]                          if_cnt,
    output logic [CNT_W-1:0]                          other_cnt,
    output logic [CNT_W-1:0]                          bad_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [0:0] {StRun, StWaitDone} state_e;

    state_e            state_q;
    logic [3:0]        cmd_mem  [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;

    logic              legal, full, empty, accept, push, pop, load_en, barrier_hs;
    logic [3:0]        head_cmd;
    logic [ADDR_W-1:0] head_addr;

    always_comb begin
        legal = 1'b0;
        case (in_cmd)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
    end

    assign full       = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty      = (level_q == '0);
    assign in_ready   = !full && !rst;
    assign accept     = in_valid && in_ready;
    assign push       = accept && legal;
    assign barrier_hs = out_valid && out_ready && (out_cmd == 4'd8 || out_cmd == 4'd9);
    // A barrier handshake blocks the refill so nothing follows it into the output register.
    assign load_en    = (state_q == StRun) && (!out_valid || out_ready) && !barrier_hs;
    assign pop        = load_en && !empty;
    assign head_cmd   = cmd_mem[rd_ptr_q];
    assign head_addr  = addr_mem[rd_ptr_q];
    assign fifo_level = level_q;

    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem[wr_ptr_q]  <= in_cmd;
            addr_mem[wr_ptr_q] <= in_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (!push && pop) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            out_valid  <= 1'b0;
            out_cmd    <= '0;
            out_addr   <= '0;
            out_tag    <= '0;
            out_index  <= '0;
            out_offset <= '0;
            out_icache <= 1'b0;
            bad_cmd    <= 1'b0;
        end else begin
            bad_cmd <= accept && !legal;
            unique case (state_q)
                StRun:      if (barrier_hs) state_q <= StWaitDone;
                StWaitDone: if (cache_done) state_q <= StRun;
                default:    state_q <= StRun;
            endcase
            if (barrier_hs) begin
                out_valid <= 1'b0;
            end else if (load_en) begin
                out_valid <= !empty;
                if (!empty) begin
                    out_cmd    <= head_cmd;
                    out_addr   <= head_addr;
                    out_tag    <= head_addr[ADDR_W-1:INDEX_BITS+OFFSET_BITS];
                    out_index  <= head_addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
                    out_offset <= head_addr[OFFSET_BITS-1:0];
                    out_icache <= (head_cmd == 4'd2);
                end
            end
        end
    end

`ifdef TRACE_DISPATCH_STATS_EN
    logic out_hs;
    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            if_cnt    <= '0;
            other_cnt <= '0;
            bad_cnt   <= '0;
        end else begin
            if (out_hs && out_cmd == 4'd0 && rd_cnt != '1) rd_cnt <= rd_cnt + CNT_W'(1);
            if (out_hs && out_cmd == 4'd1 && wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
            if (out_hs && out_cmd == 4'd2 && if_cnt != '1) if_cnt <= if_cnt + CNT_W'(1);
            // Only legal codes reach the output, so anything else is 3/4/8/9.
            if (out_hs && out_cmd > 4'd2 && other_cnt != '1) begin
                other_cnt <= other_cnt + CNT_W'(1);
            end
            if (bad_cmd && bad_cnt != '1) bad_cnt <= bad_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
